// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: mode encoding and register map shared by the LED PWM controller
package led_pwm_pkg;
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    localparam int REG_CTRL     = 0;
    localparam int REG_PRESCALE = 1;
    localparam int REG_BLINK    = 2;
    localparam int REG_STATUS   = 3;
    localparam int REG_CH_BASE  = 4;

    // CH_CFG packs duty in the low bits with the 2-bit mode directly above it
    localparam int CH_DUTY_LSB  = 0;
    localparam int CH_MODE_BITS = 2;
endpackage

// File: rtl/led_pwm_control_if.sv
// led_pwm_control_if: CPU register bus between a bus master and the LED controller
interface led_pwm_control_if #(
    parameter int address_width = 15,
    parameter int data_width    = 16
);
    logic [address_width-1:0] address_i;
    logic [data_width-1:0]    data_i;
    logic [data_width-1:0]    data_o;
    logic                     rd_wr_i;

    modport master(output address_i, data_i, rd_wr_i, input data_o);
    modport slave(input address_i, data_i, rd_wr_i, output data_o);
endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED output, selecting off/on/dim/blink from the shared counters
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PwmWidth = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                enable,
    input  logic                blink_phase,
    input  mode_e               mode,
    input  logic [PwmWidth-1:0] duty,
    input  logic [PwmWidth-1:0] pwm_cnt,
    output logic                led
);
    logic lit;
    logic led_d;

    assign lit   = pwm_cnt < duty;
    assign led_d = !enable ? 1'b0 :
                   mode == MODE_ON    ? 1'b1 :
                   mode == MODE_PWM   ? lit :
                   mode == MODE_BLINK ? blink_phase & lit : 1'b0;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) led <= 1'b0;
        else led <= led_d;
endmodule

// File: rtl/led_pwm_control.sv
// led_pwm_control: multi-channel LED controller with shared prescaler, PWM counter and blink timer
module led_pwm_control
    import led_pwm_pkg::*;
#(
    parameter int BaseAddress   = 0,
    parameter int address_width = 15,
    parameter int data_width    = 16,
    parameter int NumLeds       = 4,
    parameter int PwmWidth      = 8,
    parameter int PrescaleWidth = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    led_pwm_control_if.slave   bus,
    output logic [NumLeds-1:0] led_o
);
    localparam int CfgWidth = PwmWidth + CH_MODE_BITS;

    logic                     enable;
    logic [PrescaleWidth-1:0] prescale;
    logic [PrescaleWidth-1:0] presc_cnt;
    logic [PwmWidth-1:0]      blink;
    logic [PwmWidth-1:0]      blink_cnt;
    logic [PwmWidth-1:0]      pwm_cnt;
    logic                     blink_phase;
    logic [CfgWidth-1:0]      cfg [NumLeds];
    logic [address_width-1:0] off;
    logic [data_width-1:0]    rdata;
    logic                     tick;
    logic                     pwm_wrap;

    assign off      = bus.address_i - address_width'(BaseAddress);
    assign tick     = enable && presc_cnt == prescale;
    assign pwm_wrap = tick && &pwm_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            enable   <= 1'b0;
            prescale <= '0;
            blink    <= '0;
            for (int n = 0; n < NumLeds; n++) cfg[n] <= '0;
        end else if (bus.rd_wr_i) begin
            if (off == address_width'(REG_CTRL)) enable <= bus.data_i[0];
            if (off == address_width'(REG_PRESCALE)) prescale <= bus.data_i[PrescaleWidth-1:0];
            if (off == address_width'(REG_BLINK)) blink <= bus.data_i[PwmWidth-1:0];
            for (int n = 0; n < NumLeds; n++)
                if (off == address_width'(REG_CH_BASE + n)) cfg[n] <= bus.data_i[CfgWidth-1:0];
        end
    end

    // a PRESCALE lowered below the running count lets the count roll over the full width
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!enable) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap) begin
                blink_cnt <= blink_cnt == blink ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == blink) blink_phase <= ~blink_phase;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!bus.rd_wr_i) begin
            rdata = off == address_width'(REG_CTRL)     ? data_width'(enable) :
                    off == address_width'(REG_PRESCALE) ? data_width'(prescale) :
                    off == address_width'(REG_BLINK)    ? data_width'(blink) :
                    off == address_width'(REG_STATUS)   ? data_width'(led_o) : '0;
            for (int n = 0; n < NumLeds; n++)
                if (off == address_width'(REG_CH_BASE + n)) rdata = data_width'(cfg[n]);
        end
    end

    assign bus.data_o = rdata;

    for (genvar c = 0; c < NumLeds; c++) begin : g_ch
        led_pwm_channel #(.PwmWidth(PwmWidth)) u_ch (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .enable     (enable),
            .blink_phase(blink_phase),
            .mode       (mode_e'(cfg[c][CfgWidth-1:PwmWidth])),
            .duty       (cfg[c][CH_DUTY_LSB +: PwmWidth]),
            .pwm_cnt    (pwm_cnt),
            .led        (led_o[c])
        );
    end
endmodule

// File: tb/tb_led_pwm_control.sv
// tb_led_pwm_control: directed and randomized checks of led_pwm_control against a timing model
module tb_led_pwm_control;
    localparam int AW = 15, DW = 16, NL = 4, PW = 8, PSW = 12, BASE = 16;
    localparam int A_CTRL = BASE, A_PRE = BASE + 1, A_BLINK = BASE + 2;
    localparam int A_STATUS = BASE + 3, A_CH = BASE + 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NL-1:0] led;
    int            total = 0;
    int            bad = 0;
    int            m_p, m_b;
    int            m_mode [NL];
    int            m_duty [NL];

    led_pwm_control_if #(.address_width(AW), .data_width(DW)) bus();

    led_pwm_control #(
        .BaseAddress(BASE), .address_width(AW), .data_width(DW),
        .NumLeds(NL), .PwmWidth(PW), .PrescaleWidth(PSW)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus),
        .led_o    (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus.address_i = AW'(a);
        bus.data_i    = DW'(d);
        bus.rd_wr_i   = 1'b1;
        @(negedge clk);
        bus.rd_wr_i   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int a, input int exp);
        @(negedge clk);
        bus.address_i = AW'(a);
        bus.rd_wr_i   = 1'b0;
        #1 check(tag, bus.data_o, exp);
    endtask

    // s = clock cycles the counters have run since enable took effect
    function automatic logic [NL-1:0] model_led(input int s);
        int ticks = s / (m_p + 1);
        int pc    = ticks % (1 << PW);
        int ph    = (ticks / (1 << PW) / (m_b + 1)) % 2;
        logic [NL-1:0] r = '0;
        for (int n = 0; n < NL; n++)
            r[n] = m_mode[n] == 1 || (m_mode[n] == 2 && pc < m_duty[n]) ||
                   (m_mode[n] == 3 && ph == 1 && pc < m_duty[n]);
        return r;
    endfunction

    task automatic run(input int p, input int b, input int len);
        wr(A_CTRL, 0);
        wr(A_PRE, p);
        wr(A_BLINK, b);
        for (int n = 0; n < NL; n++) wr(A_CH + n, (m_mode[n] << PW) | m_duty[n]);
        m_p = p;
        m_b = b;
        wr(A_CTRL, 1);
        check("en_edge", led, 0);
        bus.address_i = AW'(A_STATUS);
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            check("led", led, model_led(j - 1));
            if (j % 16 == 0) check("status", bus.data_o, model_led(j - 1));
        end
    endtask

    initial begin
        bus.address_i = '0;
        bus.data_i    = '0;
        bus.rd_wr_i   = 1'b0;
        repeat (2) @(negedge clk);
        for (int a = 0; a < 8; a++) rd_check("rst_rd", A_CTRL + a, 0);
        check("rst_led", led, 0);
        @(negedge clk);
        reset_n = 1'b1;

        wr(A_CTRL, 1);
        check("en_only", led, 0);
        wr(A_CH + 2, 'h100);
        check("on_lat", led, 0);
        @(negedge clk);
        check("on", led, 4'b0100);
        rd_check("on_status", A_STATUS, 4'b0100);
        rd_check("ch2_rd", A_CH + 2, 'h100);
        wr(A_CTRL, 0);
        check("off_lat", led, 4'b0100);
        @(negedge clk);
        check("off", led, 0);
        rd_check("off_status", A_STATUS, 0);

        wr(A_PRE, 'hFFFF);
        rd_check("pre_mask", A_PRE, 'hFFF);
        wr(A_BLINK, 'hFFFF);
        rd_check("blink_mask", A_BLINK, 'hFF);
        wr(A_CH + 1, 'hFFFF);
        rd_check("cfg_mask", A_CH + 1, 'h3FF);
        wr(A_CTRL, 'hFFFE);
        rd_check("ctrl_bit0", A_CTRL, 0);
        wr(A_CH + 1, 0);

        wr(A_CTRL, 1);
        @(negedge clk);
        check("on_again", led, 4'b0100);
        wr(A_STATUS, 'hF);
        @(negedge clk);
        check("status_wr_led", led, 4'b0100);
        rd_check("status_wr_rd", A_STATUS, 4'b0100);
        rd_check("unmapped", A_CH + NL, 0);
        rd_check("below_base", BASE - 1, 0);
        wr(A_CH + NL, 'h1FF);
        for (int n = 0; n < NL; n++) rd_check("ch_keep", A_CH + n, n == 2 ? 'h100 : 0);
        check("unmapped_wr_led", led, 4'b0100);
        @(negedge clk);
        bus.address_i = AW'(A_CH + 2);
        bus.data_i    = DW'('h100);
        bus.rd_wr_i   = 1'b1;
        #1 check("rd_in_wr", bus.data_o, 0);
        @(negedge clk);
        bus.rd_wr_i   = 1'b0;

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_led", led, 0);
        bus.address_i = AW'(A_CH + 2);
        #1 check("async_cfg", bus.data_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wr(A_CH + 2, 'h100);
        repeat (3) @(negedge clk);
        check("no_resume", led, 0);
        rd_check("ctrl_after_rst", A_CTRL, 0);

        m_mode = '{2, 3, 2, 2};
        m_duty = '{64, 255, 255, 0};
        run(0, 2, 1700);
        m_mode = '{2, 0, 0, 0};
        m_duty = '{128, 0, 0, 0};
        run(3, 0, 2100);

        // lower PRESCALE while the prescaler is above the new value
        m_duty = '{1, 0, 0, 0};
        run(3, 0, 0);
        wr(A_PRE, 1);
        for (int j = 2; j <= 4700; j++) begin
            int s, pc;
            if (j > 2) @(negedge clk);
            s  = j - 1;
            pc = s < (1 << PSW) + 2 ? 0 : (1 + (s - (1 << PSW) - 2) / 2) % (1 << PW);
            check("pre_rewrite", led[0], pc < 1);
        end

        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < NL; n++) begin
                int k = $urandom_range(0, 9);
                m_mode[n] = $urandom_range(0, 3);
                m_duty[n] = k == 0 ? 0 : k == 1 ? 255 : $urandom_range(0, 255);
            end
            run($urandom_range(0, 1), $urandom_range(0, 2), 2500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_pwm_control.md
Name: led_pwm_control

Overview:
Multi-channel LED controller on the CPU register bus, and the parametrised successor of the single-bit LED control register. It drives NumLeds outputs, each with a mode (off, on, PWM dim, PWM blink) and an individual duty cycle. A shared prescaler, PWM counter and blink timer keep all channels phase-aligned. Reads are combinational, writes are registered, and the bus protocol matches the other peripherals.

Parameters:
BaseAddress, 0, first bus address of the register window
address_width, 15, bus address width
data_width, 16, bus data width; must be >= PwmWidth+2 and >= NumLeds
NumLeds, 4, number of LED channels (1..16)
PwmWidth, 8, PWM counter and duty width in bits
PrescaleWidth, 16, prescaler compare width; must be <= data_width

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
address_i  in  address_width  bus address
data_i  in  data_width  write data
data_o  out  data_width  read data, combinational
rd_wr_i  in  1  1 = write cycle, 0 = read cycle
led_o  out  NumLeds  registered LED outputs; bit n = channel n

Behaviour:
- Interface (already decided): one clock clk_i; reset_n_i is asynchronous, active-low. Every flop clears immediately on reset_n_i=0.
- Register map (word offsets from BaseAddress):
  - +0 CTRL: bit0 enable, reset 0.
  - +1 PRESCALE: [PrescaleWidth-1:0], reset 0.
  - +2 BLINK: [PwmWidth-1:0] blink half-period in PWM periods, reset 0.
  - +3 STATUS: read-only, [NumLeds-1:0] = led_o.
  - +4+n CH_CFG[n]: [PwmWidth-1:0] duty, [PwmWidth+1:PwmWidth] mode, reset 0.
- Modes: 00 OFF, 01 ON, 10 PWM, 11 BLINK.
- Writes: when rd_wr_i=1 and the address matches a writable register, that register loads data_i at the clock edge. Unused bits are ignored. Writes to STATUS or unmapped addresses do nothing.
- Reads: when rd_wr_i=0, data_o is the addressed register, zero-extended. data_o=0 for unmapped addresses and during write cycles.
- Prescaler:
  - Counts 0..PRESCALE, then returns to 0.
  - tick=1 in the cycle the count equals PRESCALE.
  - PRESCALE=0 gives tick every cycle.
  - If PRESCALE is written below the current count, the counter continues to the top of PrescaleWidth and wraps to 0; no tick is generated at the wrap.
- PWM counter:
  - Increments by 1 per tick and wraps from 2^PwmWidth-1 to 0.
  - pwm_wrap=1 on the tick that performs the wrap.
- Blink timer:
  - Counter increments on each pwm_wrap.
  - When the counter equals BLINK, blink_phase toggles and the counter clears.
  - BLINK=0 toggles blink_phase every PWM period.
- Channel output (next value):
  - OFF: 0.
  - ON: 1.
  - PWM: (pwm_cnt < duty).
  - BLINK: blink_phase & (pwm_cnt < duty).
- Duty bounds: duty=0 gives constant 0; duty=2^PwmWidth-1 is high for all but one count.
- Enable=0:
  - Prescaler, PWM counter, blink counter and blink_phase are held at 0.
  - led_o is forced to 0 in every mode, including ON.
- Enable 0->1: counting starts from 0 on the next edge. The first pwm_wrap occurs after (PRESCALE+1)*2^PwmWidth cycles.
- Latency: led_o is registered from the current counters and config. A config write at edge N is visible on led_o at edge N+1.
- Simultaneous duty change and counter update: the comparison uses the register values present before the edge.
- Reset mid-operation: all counters, config and led_o return to 0 asynchronously. Operation resumes only after CTRL is written again.

Decomposition:
- Package led_pwm_pkg:
  - mode enum (OFF, ON, PWM, BLINK) as a 2-bit logic type.
  - Register offset localparams (CTRL, PRESCALE, BLINK, STATUS, CH_BASE).
  - Field position constants for CH_CFG.
- Sub-module led_pwm_channel, instantiated NumLeds times in a generate loop:
  - Inputs: duty, mode, pwm_cnt, blink_phase, enable.
  - Output: one registered led bit.
  - Owns the mode mux and the duty comparator.
- The top level owns the register file, bus decode, prescaler, PWM counter and blink timer.

Test Plan:
1. Reset: reset_n_i=0, then read addresses +0 to +7 -> all return 0; led_o=0. Assert reset mid-count -> counters and led_o drop to 0 before the next edge.
2. ON mode: CTRL=1, CH_CFG[2]=0x0100 -> led_o=4'b0100 one edge after the write. CTRL=0 -> led_o=0 next edge. Read STATUS matches led_o.
3. PWM duty: PRESCALE=0, PwmWidth=8, CH_CFG[0]={PWM, duty=64} -> led_o[0] high exactly 64 of every 256 cycles, period 256. duty=0 -> never high. duty=255 -> high 255 of 256 cycles.
4. Prescaler: PRESCALE=3, duty=128 -> PWM period is 1024 cycles with 512 high. Write PRESCALE=1 mid-count -> no tick lost after the wrap, and the new period applies afterwards.
5. Blink: PRESCALE=0, BLINK=2, CH_CFG[1]={BLINK, duty=255} -> led_o[1] alternates between 3 PWM periods (768 cycles) of PWM activity and 768 cycles of constant 0.
6. Bus edges: read an unmapped address (+4+NumLeds) -> 0. Write STATUS -> no change. data_o=0 while rd_wr_i=1. Write at base+3+NumLeds+1 -> no channel is affected.
